de2_115_qsys_key_pio: RTL and testbench
=======================================

// Module: de2_115_qsys_key_pio
// PURPOSE
//  Avalon-MM slave input PIO: the input-direction counterpart of the LED output PIOs.
//  Samples external pushbuttons/switches through a 2-flop synchroniser and per-bit debounce.
//  Provides data, interrupt-mask and edge-capture registers, and raises a level IRQ to the CPU.
//  Sits in the QSYS system alongside the output PIOs on the same 2-bit address bus.
// PARAMETERS
//  WIDTH            4      number of input bits (1..32)
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles before a bit is accepted; 0 = bypass
//  EDGE_TYPE        0      edge-capture type: 0 = falling, 1 = rising, 2 = any
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  in_port     in   WIDTH  asynchronous external inputs
//  readdata    out  32     read data, 1-cycle latency
//  irq         out  1      level interrupt
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset is synchronous and active-high.
//  Reset values (cycle after reset=1 sampled):
//   - readdata = 0, irq = 0, irq_mask = 0, edge_capture = 0.
//   - Sync flops and debounced value = 0; debounce counters = 0.
//  Synchroniser and debounce:
//   - in_port -> sync1 -> sync2, per bit.
//   - Per bit, sync2 != deb: count++ each cycle. When count reaches DEBOUNCE_CYCLES-1, deb <= sync2 and count <= 0.
//   - sync2 == deb: count <= 0.
//   - Counter width is $clog2(DEBOUNCE_CYCLES+1). It never wraps.
//   - DEBOUNCE_CYCLES = 0: deb = sync2 (wire).
//   - Latency from a stable input change to deb: 2 + DEBOUNCE_CYCLES cycles.
//  Edge detect:
//   - deb_d <= deb.
//   - Falling: deb_d & ~deb. Rising: ~deb_d & deb. Any: deb_d ^ deb.
//  Register map (word address):
//   - 0 data: RO. Returns deb, zero-extended to 32 bits. Writes are ignored.
//   - 1: reserved. Reads 0, writes ignored.
//   - 2 irq_mask: RW, [WIDTH-1:0].
//   - 3 edge_capture: RO/W1C.
//  Edge capture:
//   - A bit sets on a detected edge.
//   - Writing 1 to a bit clears it; writing 0 leaves it unchanged.
//   - An edge and a W1C on the same bit in the same cycle: the bit stays set (set wins).
//  Access rules:
//   - Write: accepted when chipselect & ~write_n.
//   - Read: readdata <= mux(address) every cycle, registered. The value reflects register state before any same-cycle write.
//  irq:
//   - Registered: irq <= |(edge_capture_next & irq_mask_next).
//   - Asserts 1 cycle after edge_capture sets with the mask bit high.
//   - Deasserts 1 cycle after a clear or unmask.
//  Reset mid-operation:
//   - All state returns to reset values; a pending irq drops the next cycle.
//   - Inputs held low through reset produce no spurious edge, since deb and deb_d both start at 0.
// STRUCTURE
//  Package de2_115_qsys_pio_pkg:
//   - ADDR_DATA = 2'd0, ADDR_IRQMASK = 2'd2, ADDR_EDGECAP = 2'd3.
//   - EDGE_FALLING = 0, EDGE_RISING = 1, EDGE_ANY = 2.
//  Sub-module pio_debounce_bit:
//   - Synchroniser, counter and deb for one bit; params DEBOUNCE_CYCLES.
//   - Instantiated WIDTH times via generate.
//  Top level holds deb_d, edge logic, registers, read mux and irq.
// TESTING (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated)
//  1. Reset: hold reset 3 cycles with in_port=4'hF.
//     -> readdata=0, irq=0. After release, read addr0 returns 0xF by cycle 2+4+1; edge_capture=0.
//  2. Bounce: in_port[0] 1->0 for 2 cycles, back to 1, then 0 steady.
//     -> deb[0] falls only 6 cycles after the steady 0. edge_capture=0x1 exactly once.
//  3. IRQ: write irq_mask=0x1, then a falling edge on bit0.
//     -> irq=1 one cycle after edge_capture[0] sets.
//     -> Write 0x1 to addr3: edge_capture=0, irq=0 the next cycle.
//  4. Simultaneous: W1C of bit2 in the same cycle as a new falling edge on bit2.
//     -> edge_capture[2] stays 1.
//     -> W1C of 0x0 leaves 0x4 intact.
//  5. Mask/unmask: edge on bit3 with mask=0 -> irq stays 0. Write mask=0x8 -> irq=1 next cycle.
//  6. EDGE_TYPE=2, DEBOUNCE_CYCLES=0: toggle bit1 0->1->0.
//     -> Each edge sets edge_capture[1]. Read addr1 returns 0. Write to addr0 has no effect.

Source files
------------

// File: rtl/de2_115_qsys_pio_pkg.sv
// Shared register map, edge-type codes and read-mux helper for the QSYS PIO blocks.
package de2_115_qsys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_FALLING = 0;
  localparam int EDGE_RISING  = 1;
  localparam int EDGE_ANY     = 2;

  // Reserved and unknown addresses read back as zero.
  function automatic logic [31:0] pio_read_mux(
    input logic [1:0]  addr,
    input logic [31:0] data,
    input logic [31:0] mask,
    input logic [31:0] cap
  );
    case (addr)
      ADDR_DATA:    return data;
      ADDR_IRQMASK: return mask;
      ADDR_EDGECAP: return cap;
      default:      return '0;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a stable-count debounce filter.
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic deb
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = in_bit;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign deb = sync2_q;
    end else begin : g_filter
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] count_q, count_d;
      logic          deb_q, deb_d;

      // Any cycle where the input agrees with the accepted value restarts the count.
      always_comb begin
        count_d = '0;
        deb_d   = deb_q;
        if (sync2_q != deb_q) begin
          if (count_q == CNT_LAST) begin
            deb_d = sync2_q;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          count_q <= '0;
          deb_q   <= 1'b0;
        end else begin
          count_q <= count_d;
          deb_q   <= deb_d;
        end
      end

      assign deb = deb_q;
    end
  endgenerate

endmodule

// File: rtl/de2_115_qsys_key_pio.sv
// Avalon-MM input PIO: debounced data, interrupt mask, W1C edge capture and level IRQ.
module de2_115_qsys_key_pio
  import de2_115_qsys_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_FALLING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;

  logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk    (clk),
        .reset  (reset),
        .in_bit (in_port[gi]),
        .deb    (deb[gi])
      );
    end

    if (WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISING: edge_det = ~deb_prev_q & deb;
      EDGE_ANY:    edge_det = deb_prev_q ^ deb;
      default:     edge_det = deb_prev_q & ~deb;
    endcase
  end

  always_comb begin
    deb_prev_d = deb;

    irq_mask_d = irq_mask_q;
    if (wr_en && address == ADDR_IRQMASK) begin
      irq_mask_d = wdata;
    end

    // Clear first, then OR in new edges so a same-cycle edge survives the W1C.
    edge_capture_d = edge_capture_q;
    if (wr_en && address == ADDR_EDGECAP) begin
      edge_capture_d = edge_capture_d & ~wdata;
    end
    edge_capture_d = edge_capture_d | edge_det;

    irq_d      = |(edge_capture_d & irq_mask_d);
    readdata_d = pio_read_mux(address, 32'(deb), 32'(irq_mask_q), 32'(edge_capture_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_prev_q     <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      deb_prev_q     <= deb_prev_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_de2_115_qsys_key_pio.sv
// Directed scoreboard bench: falling-edge PIO with short debounce, plus an any-edge bypass instance.
module tb_de2_115_qsys_key_pio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_a = 4'hF;
  logic [3:0]  in_b = 4'h0;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          sel_b;
  } exp_t;
  exp_t sb[$];

  de2_115_qsys_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  de2_115_qsys_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input bit sel_b, input string tag);
    exp_t e;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    e.tag = tag; e.exp = exp; e.sel_b = sel_b;
    sb.push_back(e);
    step();
    e = sb.pop_front();
    check(e.tag, e.sel_b ? rd_b : rd_a, e.exp);
    $display("rd  %s dut=%s addr=%0d data=0x%08h", e.tag, e.sel_b ? "b" : "a", a,
             e.sel_b ? rd_b : rd_a);
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("wr  addr=%0d data=0x%08h", a, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. reset with inputs high
    idle(3);
    check("rst_readdata_a", rd_a, 32'h0);
    check("rst_irq_a", {31'd0, irq_a}, 32'h0);
    check("rst_readdata_b", rd_b, 32'h0);
    reset = 1'b0;
    idle(5);
    rd(2'd0, 32'h0, 0, "data_before_debounce");
    rd(2'd0, 32'hF, 0, "data_after_debounce");
    rd(2'd3, 32'h0, 0, "cap_after_reset");

    // 2. bounce on bit0, then steady low
    in_a = 4'hE;
    rd(2'd0, 32'hF, 0, "bounce_low_0");
    rd(2'd0, 32'hF, 0, "bounce_low_1");
    in_a = 4'hF;
    for (int i = 0; i < 6; i++) rd(2'd0, 32'hF, 0, "bounce_filtered");
    in_a = 4'hE;
    for (int i = 0; i < 5; i++) rd(2'd3, 32'h0, 0, "cap_wait");
    rd(2'd0, 32'hF, 0, "deb_fall_early");
    rd(2'd0, 32'hE, 0, "deb_fall_at_6");
    rd(2'd3, 32'h1, 0, "cap_set_once");
    rd(2'd3, 32'h1, 0, "cap_still_once");
    check("irq_masked_off", {31'd0, irq_a}, 32'h0);

    // 3. irq on bit0 falling edge, then clear
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, 0, "cap_cleared");
    in_a = 4'hF;
    idle(7);
    rd(2'd0, 32'hF, 0, "bit0_back_high");
    rd(2'd3, 32'h0, 0, "rising_ignored");
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h1, 0, "mask_readback");
    in_a = 4'hE;
    idle(6);
    check("irq_before_edge", {31'd0, irq_a}, 32'h0);
    step();
    check("irq_on_edge", {31'd0, irq_a}, 32'h1);
    rd(2'd3, 32'h1, 0, "cap_bit0_irq");
    wr(2'd3, 32'h1);
    check("irq_after_w1c", {31'd0, irq_a}, 32'h0);
    rd(2'd3, 32'h0, 0, "cap_after_w1c");

    // 4. W1C and new edge on bit2 in the same cycle
    in_a = 4'hA;
    idle(6);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4, 0, "set_wins_over_w1c");
    wr(2'd3, 32'h0);
    rd(2'd3, 32'h4, 0, "w1c_zero_keeps");
    rd(2'd0, 32'hA, 0, "data_bit2_low");

    // 5. masked edge on bit3, then unmask
    in_a = 4'h2;
    idle(7);
    check("irq_bit3_masked", {31'd0, irq_a}, 32'h0);
    rd(2'd3, 32'hC, 0, "cap_bit3");
    wr(2'd2, 32'h8);
    check("irq_on_unmask", {31'd0, irq_a}, 32'h1);
    rd(2'd2, 32'h8, 0, "mask_bit3");
    reset = 1'b1;
    step();
    check("irq_mid_reset", {31'd0, irq_a}, 32'h0);
    check("readdata_mid_reset", rd_a, 32'h0);
    reset = 1'b0;
    rd(2'd3, 32'h0, 0, "cap_after_mid_reset");
    rd(2'd2, 32'h0, 0, "mask_after_mid_reset");

    // 6. any-edge, no debounce
    in_b = 4'h2;
    idle(2);
    rd(2'd3, 32'h0, 1, "b_rise_pending");
    rd(2'd3, 32'h2, 1, "b_rise_captured");
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, 1, "b_cap_cleared");
    in_b = 4'h0;
    idle(3);
    rd(2'd3, 32'h2, 1, "b_fall_captured");
    rd(2'd1, 32'h0, 1, "b_reserved_read");
    rd(2'd1, 32'h0, 0, "a_reserved_read");
    wr(2'd0, 32'hF);
    rd(2'd0, 32'h0, 1, "b_data_write_ignored");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
